wt_l15_req_arb: RTL and testbench
=================================

WT_L15_REQ_ARB -- requirements
Module: wt_l15_req_arb

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, meaning max in-flight L1.5 transactions per requester (2..15).
REQ-002 SHALL have parameter TID_WIDTH, default 2, meaning transaction-ID width.
REQ-003 SHALL have the following ports, as name, direction, width and meaning:
- clk_i  in  1  sole clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- icache_req_vld_i  in  1  I$ request valid; held with fields until ready.
- icache_req_rdy_o  out  1  I$ request accepted this cycle.
- icache_req_i  in  115  {rqtype[4:0], nc, size[2:0], tid[TID_WIDTH-1:0], paddr[39:0], data[63:0]}; width shown for TID_WIDTH=2.
- dcache_req_vld_i, dcache_req_rdy_o, dcache_req_i  same as I$, for D$.
- l15_val_o  out  1  L1.5 request valid.
- l15_req_o  out  115  latched request fields.
- l15_header_ack_i  in  1  L1.5 accepted the request.
- l15_rtrn_val_i  in  1  L1.5 return valid.
- l15_returntype_i  in  4  return type.
- l15_req_ack_o  out  1  return consumed.
- icache_rtrn_vld_o  out  1  return belongs to I$.
- dcache_rtrn_vld_o  out  1  return belongs to D$.
- icache_cnt_o, dcache_cnt_o  out  4  outstanding counts.
- err_o  out  1  sticky protocol error.

Function
REQ-004 SHALL implement FSM IDLE and ISSUE, with reset state IDLE.
REQ-005 In IDLE, a requester SHALL be eligible when vld=1 and cnt<MAX_OUTSTANDING.
REQ-006 In IDLE, grant selection SHALL be round-robin: with both requesters eligible, the one not granted last wins; after reset D$ has priority.
REQ-007 On grant, the block SHALL assert the winner's rdy_o for exactly that cycle, latch its fields into l15_req_o, increment its cnt, and go to ISSUE.
REQ-008 In ISSUE, l15_val_o SHALL be 1 and l15_req_o SHALL be stable until l15_header_ack_i=1.
REQ-009 On the ack cycle the block SHALL return to IDLE, and l15_val_o SHALL be 0 the next cycle.
REQ-010 Grant-to-l15_val_o latency SHALL be 1 cycle; the minimum spacing between grants SHALL be 2 cycles.
REQ-011 Both rdy_o outputs SHALL be 0 in ISSUE; rdy_o SHALL never be 1 while the corresponding vld_i is 0.
REQ-012 l15_req_ack_o SHALL equal l15_rtrn_val_i combinationally, so returns are always accepted.
REQ-013 Return routing SHALL be:
- IFILL_RET (4'b0001) -> icache_rtrn_vld_o=1, icache cnt decremented.
- LOAD_RET (0000), ST_ACK (0100), INT_RET (0111) and ATOMIC_RES (1110) -> dcache_rtrn_vld_o=1, dcache cnt decremented.
- EVICT_REQ (0011) -> dcache_rtrn_vld_o=1, no decrement.
- Any other type -> neither output, err_o set.
REQ-014 A grant and a decrement for the same requester in the same cycle SHALL leave that cnt unchanged.
REQ-015 A decrement when cnt=0 SHALL keep cnt at 0 and set err_o.
REQ-016 cnt SHALL never exceed MAX_OUTSTANDING; a requester at the limit SHALL not be granted, and the other requester remains eligible.
REQ-017 l15_header_ack_i received in IDLE SHALL be ignored and SHALL set err_o.

Reset
REQ-018 While rst_i=1 the block SHALL hold these next-edge values: FSM=IDLE, l15_val_o=0, l15_req_o=0, both rdy_o=0, both cnt=0, err_o=0, round-robin pointer=D$-priority.
REQ-019 Reset asserted in ISSUE SHALL abandon the latched request; l15_val_o SHALL be 0 from the following cycle, and no rdy_o pulse is regenerated.
REQ-020 icache_rtrn_vld_o, dcache_rtrn_vld_o and l15_req_ack_o SHALL be 0 while rst_i=1.

Verification
REQ-021 The bench SHALL cover a simultaneous first request: both vld=1 after reset -> D$ rdy pulse in cycle 0, l15_val_o=1 in cycle 1; after the ack, I$ granted in the next IDLE cycle.
REQ-022 The bench SHALL cover the outstanding limit: 4 D$ loads with no returns -> dcache_cnt_o=4 and D$ blocked; an I$ request is still granted; one LOAD_RET -> cnt=3 and D$ granted again.
REQ-023 The bench SHALL cover a stalled header ack: ack delayed 5 cycles -> l15_val_o=1 and l15_req_o constant for 5 cycles, with no rdy pulses during that time.
REQ-024 The bench SHALL cover a simultaneous grant and return: D$ grant coinciding with ST_ACK at dcache_cnt_o=2 -> cnt remains 2.
REQ-025 The bench SHALL cover protocol errors: IFILL_RET with icache_cnt_o=0 -> cnt stays 0 and err_o=1 until reset; returntype 4'b1111 -> no rtrn_vld and err_o=1.
REQ-026 The bench SHALL cover reset mid-ISSUE: rst_i pulsed while l15_val_o=1 -> l15_val_o=0 and counts 0 the next cycle; a new request is granted with D$ priority.

Source files
------------

// File: rtl/wt_l15_req_arb_if.sv
// Request, L1.5 handshake and return-routing bundle shared by the I$/D$ arbiter and its environment.
interface wt_l15_req_arb_if #(
  parameter int TID_WIDTH = 2
);
  localparam int ReqWidth = 113 + TID_WIDTH;

  logic                icache_req_vld_i;
  logic                icache_req_rdy_o;
  logic [ReqWidth-1:0] icache_req_i;
  logic                dcache_req_vld_i;
  logic                dcache_req_rdy_o;
  logic [ReqWidth-1:0] dcache_req_i;

  logic                l15_val_o;
  logic [ReqWidth-1:0] l15_req_o;
  logic                l15_header_ack_i;
  logic                l15_rtrn_val_i;
  logic [3:0]          l15_returntype_i;
  logic                l15_req_ack_o;

  logic                icache_rtrn_vld_o;
  logic                dcache_rtrn_vld_o;
  logic [3:0]          icache_cnt_o;
  logic [3:0]          dcache_cnt_o;
  logic                err_o;

  modport slave (
    input  icache_req_vld_i, icache_req_i, dcache_req_vld_i, dcache_req_i,
    input  l15_header_ack_i, l15_rtrn_val_i, l15_returntype_i,
    output icache_req_rdy_o, dcache_req_rdy_o, l15_val_o, l15_req_o, l15_req_ack_o,
    output icache_rtrn_vld_o, dcache_rtrn_vld_o, icache_cnt_o, dcache_cnt_o, err_o
  );

  modport master (
    output icache_req_vld_i, icache_req_i, dcache_req_vld_i, dcache_req_i,
    output l15_header_ack_i, l15_rtrn_val_i, l15_returntype_i,
    input  icache_req_rdy_o, dcache_req_rdy_o, l15_val_o, l15_req_o, l15_req_ack_o,
    input  icache_rtrn_vld_o, dcache_rtrn_vld_o, icache_cnt_o, dcache_cnt_o, err_o
  );
endinterface

// File: rtl/wt_l15_req_arb.sv
// Round-robin arbiter between I$ and D$ L1.5 requests with per-requester outstanding
// tracking, return routing and a sticky protocol-error flag.
module wt_l15_req_arb #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TID_WIDTH       = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  wt_l15_req_arb_if.slave bus
);
  localparam int         ReqWidth  = 113 + TID_WIDTH;
  localparam logic [3:0] MaxCnt    = 4'(MAX_OUTSTANDING);
  localparam logic [3:0] LoadRet   = 4'b0000;
  localparam logic [3:0] IfillRet  = 4'b0001;
  localparam logic [3:0] EvictReq  = 4'b0011;
  localparam logic [3:0] StAck     = 4'b0100;
  localparam logic [3:0] IntRet    = 4'b0111;
  localparam logic [3:0] AtomicRes = 4'b1110;

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e              state_q;
  logic                l15_val_q;
  logic [ReqWidth-1:0] l15_req_q;
  logic                dcache_prio_q;
  logic [3:0]          icache_cnt_q, icache_cnt_d;
  logic [3:0]          dcache_cnt_q, dcache_cnt_d;
  logic                err_q, err_d;

  logic icache_elig, dcache_elig, icache_gnt, dcache_gnt;
  logic icache_rtrn, dcache_rtrn, icache_dec, dcache_dec, rtrn_unknown;

  // Grants only happen in IDLE; on a tie the pointer picks whoever was not served last.
  always_comb begin
    icache_elig = !rst_i && (state_q == IDLE) && bus.icache_req_vld_i && (icache_cnt_q < MaxCnt);
    dcache_elig = !rst_i && (state_q == IDLE) && bus.dcache_req_vld_i && (dcache_cnt_q < MaxCnt);
    dcache_gnt  = dcache_elig && (dcache_prio_q || !icache_elig);
    icache_gnt  = icache_elig && !dcache_gnt;
  end

  always_comb begin
    icache_rtrn  = 1'b0;
    dcache_rtrn  = 1'b0;
    icache_dec   = 1'b0;
    dcache_dec   = 1'b0;
    rtrn_unknown = 1'b0;
    if (!rst_i && bus.l15_rtrn_val_i) begin
      case (bus.l15_returntype_i)
        IfillRet: begin
          icache_rtrn = 1'b1;
          icache_dec  = 1'b1;
        end
        LoadRet, StAck, IntRet, AtomicRes: begin
          dcache_rtrn = 1'b1;
          dcache_dec  = 1'b1;
        end
        EvictReq: dcache_rtrn  = 1'b1;
        default:  rtrn_unknown = 1'b1;
      endcase
    end
  end

  // A same-cycle grant and completion cancel; an underflowing completion is clamped at zero.
  function automatic logic [3:0] next_cnt(input logic [3:0] cnt, input logic inc, input logic dec);
    logic [3:0] nxt;
    nxt = cnt;
    if (inc && !dec) begin
      nxt = cnt + 4'd1;
    end else if (dec && !inc && (cnt != 4'd0)) begin
      nxt = cnt - 4'd1;
    end
    return nxt;
  endfunction

  always_comb begin
    icache_cnt_d = next_cnt(icache_cnt_q, icache_gnt, icache_dec);
    dcache_cnt_d = next_cnt(dcache_cnt_q, dcache_gnt, dcache_dec);
    err_d = err_q
          | rtrn_unknown
          | (icache_dec && (icache_cnt_q == 4'd0))
          | (dcache_dec && (dcache_cnt_q == 4'd0))
          | ((state_q == IDLE) && bus.l15_header_ack_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      l15_val_q     <= 1'b0;
      l15_req_q     <= '0;
      dcache_prio_q <= 1'b1;
      icache_cnt_q  <= 4'd0;
      dcache_cnt_q  <= 4'd0;
      err_q         <= 1'b0;
    end else begin
      icache_cnt_q <= icache_cnt_d;
      dcache_cnt_q <= dcache_cnt_d;
      err_q        <= err_d;
      case (state_q)
        IDLE: begin
          if (icache_gnt || dcache_gnt) begin
            state_q       <= ISSUE;
            l15_val_q     <= 1'b1;
            l15_req_q     <= dcache_gnt ? bus.dcache_req_i : bus.icache_req_i;
            dcache_prio_q <= icache_gnt;
          end
        end
        ISSUE: begin
          if (bus.l15_header_ack_i) begin
            state_q   <= IDLE;
            l15_val_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          l15_val_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.icache_req_rdy_o  = icache_gnt;
  assign bus.dcache_req_rdy_o  = dcache_gnt;
  assign bus.l15_val_o         = l15_val_q;
  assign bus.l15_req_o         = l15_req_q;
  assign bus.l15_req_ack_o     = !rst_i && bus.l15_rtrn_val_i;
  assign bus.icache_rtrn_vld_o = icache_rtrn;
  assign bus.dcache_rtrn_vld_o = dcache_rtrn;
  assign bus.icache_cnt_o      = icache_cnt_q;
  assign bus.dcache_cnt_o      = dcache_cnt_q;
  assign bus.err_o             = err_q;
endmodule

// File: tb/tb_wt_l15_req_arb.sv
// Directed scenarios plus randomized traffic for wt_l15_req_arb, checked against a
// transaction-level model that tracks outstanding requests as queues of transaction IDs.
module tb_wt_l15_req_arb;
  localparam int MaxOut = 4;
  localparam int TidW   = 2;
  localparam int ReqW   = 113 + TidW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wt_l15_req_arb_if #(.TID_WIDTH(TidW)) bus ();

  wt_l15_req_arb #(
    .MAX_OUTSTANDING(MaxOut),
    .TID_WIDTH      (TidW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model: outstanding transactions per requester, whether a request is on the L1.5 bus,
  // what it carries, who has tie priority and whether any protocol violation has happened.
  int              iOut[$];
  int              dOut[$];
  bit              busy    = 1'b0;
  bit              dPrio   = 1'b1;
  bit              errSeen = 1'b0;
  logic [ReqW-1:0] issued  = '0;
  logic [ReqW-1:0] iData;
  logic [ReqW-1:0] dData;
  bit              expGntI, expGntD;

  logic            obsRdyI, obsRdyD, obsVal, obsRtrnI, obsRtrnD, obsAck, obsErr;
  logic [3:0]      obsCntI, obsCntD;
  logic [ReqW-1:0] obsReq;
  logic [ReqW-1:0] stallReq;

  function automatic logic [ReqW-1:0] randReq();
    logic [127:0] raw;
    raw = {$urandom, $urandom, $urandom, $urandom};
    return raw[ReqW-1:0];
  endfunction

  function automatic int tidOf(input logic [ReqW-1:0] r);
    return int'(r[104 +: TidW]);
  endfunction

  // 0 = unknown type, 1 = I$ fill, 2 = D$ completion, 3 = D$ eviction (nothing retired)
  function automatic int returnOwner(input logic [3:0] rt);
    int owner;
    case (rt)
      4'b0001:                            owner = 1;
      4'b0000, 4'b0100, 4'b0111, 4'b1110: owner = 2;
      4'b0011:                            owner = 3;
      default:                            owner = 0;
    endcase
    return owner;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive at the falling edge, check just after, advance the model at the rising edge.
  task automatic applyStimulus(input logic r, input logic iv, input logic dv, input logic ack,
                               input logic rv, input logic [3:0] rt);
    int owner;
    bit eligI, eligD, decI, decD;
    @(negedge clk);
    rst                  = r;
    bus.icache_req_vld_i = iv;
    bus.dcache_req_vld_i = dv;
    bus.icache_req_i     = iData;
    bus.dcache_req_i     = dData;
    bus.l15_header_ack_i = ack;
    bus.l15_rtrn_val_i   = rv;
    bus.l15_returntype_i = rt;
    #1;
    owner   = rv ? returnOwner(rt) : -1;
    eligI   = !r && !busy && iv && (iOut.size() < MaxOut);
    eligD   = !r && !busy && dv && (dOut.size() < MaxOut);
    expGntD = eligD && (dPrio || !eligI);
    expGntI = eligI && !expGntD;
    decI    = !r && (owner == 1);
    decD    = !r && (owner == 2);

    obsRdyI  = bus.icache_req_rdy_o;
    obsRdyD  = bus.dcache_req_rdy_o;
    obsVal   = bus.l15_val_o;
    obsReq   = bus.l15_req_o;
    obsCntI  = bus.icache_cnt_o;
    obsCntD  = bus.dcache_cnt_o;
    obsErr   = bus.err_o;
    obsRtrnI = bus.icache_rtrn_vld_o;
    obsRtrnD = bus.dcache_rtrn_vld_o;
    obsAck   = bus.l15_req_ack_o;

    checkOutput("icache_rdy", 128'(obsRdyI), 128'(expGntI));
    checkOutput("dcache_rdy", 128'(obsRdyD), 128'(expGntD));
    checkOutput("l15_val", 128'(obsVal), 128'(busy));
    checkOutput("l15_req", 128'(obsReq), 128'(issued));
    checkOutput("icache_cnt", 128'(obsCntI), 128'(iOut.size()));
    checkOutput("dcache_cnt", 128'(obsCntD), 128'(dOut.size()));
    checkOutput("err", 128'(obsErr), 128'(errSeen));
    checkOutput("icache_rtrn", 128'(obsRtrnI), 128'(!r && (owner == 1)));
    checkOutput("dcache_rtrn", 128'(obsRtrnD), 128'(!r && (owner == 2 || owner == 3)));
    checkOutput("l15_req_ack", 128'(obsAck), 128'(!r && rv));

    @(posedge clk);
    if (r) begin
      iOut.delete();
      dOut.delete();
      busy    = 1'b0;
      dPrio   = 1'b1;
      errSeen = 1'b0;
      issued  = '0;
    end else begin
      if (rv && owner == 0) errSeen = 1'b1;
      if (ack && !busy) errSeen = 1'b1;
      if (decI && iOut.size() == 0) errSeen = 1'b1;
      if (decD && dOut.size() == 0) errSeen = 1'b1;
      if (decI && !expGntI && iOut.size() > 0) void'(iOut.pop_front());
      if (decD && !expGntD && dOut.size() > 0) void'(dOut.pop_front());
      if (expGntI && !decI) iOut.push_back(tidOf(iData));
      if (expGntD && !decD) dOut.push_back(tidOf(dData));
      if (busy && ack) busy = 1'b0;
      if (expGntI || expGntD) begin
        busy   = 1'b1;
        issued = expGntD ? dData : iData;
        dPrio  = expGntI;
      end
      if (expGntI) iData = randReq();
      if (expGntD) dData = randReq();
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic grantAndAck(input logic iv, input logic dv);
    applyStimulus(1'b0, iv, dv, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
  endtask

  initial begin
    bit       iPend, dPend, ackR, rvR;
    logic [3:0] rtR;
    int       k;
    rst                  = 1'b1;
    iData                = randReq();
    dData                = randReq();
    bus.icache_req_vld_i = 1'b0;
    bus.dcache_req_vld_i = 1'b0;
    bus.icache_req_i     = '0;
    bus.dcache_req_i     = '0;
    bus.l15_header_ack_i = 1'b0;
    bus.l15_rtrn_val_i   = 1'b0;
    bus.l15_returntype_i = 4'd0;

    $display("[TB] simultaneous first request");
    doReset();
    checkOutput("reset_val", 128'(obsVal), 128'(0));
    checkOutput("reset_cnt_d", 128'(obsCntD), 128'(0));
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    checkOutput("first_d_rdy", 128'(obsRdyD), 128'(1));
    checkOutput("first_i_rdy", 128'(obsRdyI), 128'(0));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    checkOutput("first_val", 128'(obsVal), 128'(1));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    checkOutput("second_i_rdy", 128'(obsRdyI), 128'(1));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);

    $display("[TB] outstanding limit");
    doReset();
    for (int i = 0; i < 4; i++) grantAndAck(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    checkOutput("limit_cnt_d", 128'(obsCntD), 128'(4));
    checkOutput("limit_d_blocked", 128'(obsRdyD), 128'(0));
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    checkOutput("limit_i_granted", 128'(obsRdyI), 128'(1));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
    checkOutput("limit_load_ret", 128'(obsRtrnD), 128'(1));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    checkOutput("limit_cnt_after_ret", 128'(obsCntD), 128'(3));
    checkOutput("limit_d_regranted", 128'(obsRdyD), 128'(1));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);

    $display("[TB] stalled header ack");
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      if (i == 0) stallReq = obsReq;
      checkOutput("stall_val", 128'(obsVal), 128'(1));
      checkOutput("stall_req_stable", 128'(obsReq), 128'(stallReq));
      checkOutput("stall_no_rdy", 128'({obsRdyI, obsRdyD}), 128'(0));
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    checkOutput("stall_rr_i", 128'(obsRdyI), 128'(1));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);

    $display("[TB] simultaneous grant and return");
    doReset();
    grantAndAck(1'b0, 1'b1);
    grantAndAck(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0100);
    checkOutput("sim_d_rdy", 128'(obsRdyD), 128'(1));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    checkOutput("sim_cnt_d", 128'(obsCntD), 128'(2));

    $display("[TB] protocol errors");
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      checkOutput("underflow_cnt_i", 128'(obsCntI), 128'(0));
      checkOutput("underflow_err", 128'(obsErr), 128'(1));
    end
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1111);
    checkOutput("badtype_err_clear", 128'(obsErr), 128'(0));
    checkOutput("badtype_no_rtrn", 128'({obsRtrnI, obsRtrnD}), 128'(0));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    checkOutput("badtype_err", 128'(obsErr), 128'(1));
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    checkOutput("idle_ack_err", 128'(obsErr), 128'(1));
    checkOutput("idle_ack_val", 128'(obsVal), 128'(0));

    $display("[TB] reset during issue");
    doReset();
    grantAndAck(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    checkOutput("rst_mid_val_before", 128'(obsVal), 128'(1));
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0000);
    checkOutput("rst_mid_no_rdy", 128'({obsRdyI, obsRdyD}), 128'(0));
    checkOutput("rst_mid_no_rtrn", 128'({obsRtrnI, obsRtrnD, obsAck}), 128'(0));
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    checkOutput("rst_mid_val_after", 128'(obsVal), 128'(0));
    checkOutput("rst_mid_cnts", 128'({obsCntI, obsCntD}), 128'(0));
    checkOutput("rst_mid_d_prio", 128'(obsRdyD), 128'(1));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);

    $display("[TB] randomized traffic");
    doReset();
    iPend = 1'b0;
    dPend = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!iPend) iPend = ($urandom_range(0, 2) == 0);
      if (!dPend) dPend = ($urandom_range(0, 1) == 0);
      ackR = busy && ($urandom_range(0, 2) != 0);
      rvR  = 1'b0;
      rtR  = 4'd0;
      if ($urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, 3);
        if (k == 0 && iOut.size() > 0) begin
          rvR = 1'b1;
          rtR = 4'b0001;
        end else if (k >= 1 && k <= 2 && dOut.size() > 0) begin
          rvR = 1'b1;
          case ($urandom_range(0, 3))
            0:       rtR = 4'b0000;
            1:       rtR = 4'b0100;
            2:       rtR = 4'b0111;
            default: rtR = 4'b1110;
          endcase
        end else if (k == 3) begin
          rvR = 1'b1;
          rtR = 4'b0011;
        end
      end
      applyStimulus(1'b0, iPend, dPend, ackR, rvR, rtR);
      if (expGntI) iPend = 1'b0;
      if (expGntD) dPend = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
